// File: rtl/argmax_classifier.sv
// Argmax classifier: captures a score vector, scans it one element
// per cycle and hands off the winning class on a valid/ready port.
module argmax_classifier #(
  parameter int BitSize    = 32,
  parameter int NumClasses = 2,
  parameter int CountW     = 8,
  localparam int IdxW =
    (NumClasses > 1) ? $clog2(NumClasses) : 1
) (
  input  logic                                clk,
  input  logic                                res_n,
  input  logic                                in_valid,
  input  logic [NumClasses-1:0][BitSize-1:0]  in_data,
  input  logic                                in_done,
  output logic                                in_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [IdxW-1:0]                     out_class,
  output logic [BitSize-1:0]                  out_score,
  output logic                                out_last,
  output logic [CountW-1:0]                   out_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_e;

  typedef logic [NumClasses-1:0][BitSize-1:0] vec_t;

  localparam logic [IdxW-1:0] LastPtr =
    IdxW'(NumClasses - 1);
  localparam logic [IdxW-1:0] FirstPtr =
    IdxW'(1);

  state_e             state_q, state_d;
  vec_t               buf_q, buf_d;
  logic [BitSize-1:0] best_q, best_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic               done_q, done_d;
  logic [CountW-1:0]  cnt_q, cnt_d;

  logic [BitSize-1:0] elem;
  logic               gt;

  assign elem = buf_q[ptr_q];
  assign gt   = $signed(elem) > $signed(best_q);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    best_d    = best_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    done_d    = done_q | in_done;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_data;
          best_d  = in_data[0];
          idx_d   = '0;
          ptr_d   = FirstPtr;
          state_d = (NumClasses == 1) ? HOLD : SCAN;
        end
      end
      SCAN: begin
        // strict compare keeps the lower index on ties
        if (gt) begin
          best_d = elem;
          idx_d  = ptr_q;
        end
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastPtr) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
          if (done_q) begin
            done_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_class = idx_q;
  assign out_score = best_q;
  assign out_last  = out_valid & done_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: scoreboard of expected winners
// checked against each handed-off result.
module tb_argmax_classifier;

  logic              clk = 1'b0;
  logic              res_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [3:0][31:0]  in_data = '0;
  logic              in_done = 1'b0;
  logic              out_ready = 1'b1;

  logic              in_ready, out_valid, out_last;
  logic [1:0]        out_class;
  logic [31:0]       out_score;
  logic [7:0]        out_count;

  logic              w_in_ready, w_out_valid, w_out_last;
  logic [1:0]        w_out_class;
  logic [31:0]       w_out_score;
  logic [1:0]        w_out_count;

  argmax_classifier #(
    .BitSize(32), .NumClasses(4), .CountW(8)
  ) dut (
    .clk(clk), .res_n(res_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_done(in_done), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score),
    .out_last(out_last), .out_count(out_count)
  );

  argmax_classifier #(
    .BitSize(32), .NumClasses(4), .CountW(2)
  ) dut_w (
    .clk(clk), .res_n(res_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_done(in_done), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_class(w_out_class), .out_score(w_out_score),
    .out_last(w_out_last), .out_count(w_out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  cls;
    logic [31:0] score;
    logic        last;
  } res_t;

  res_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic res_t model(
    input logic [3:0][31:0] v, input logic last);
    res_t r;
    logic signed [31:0] b;
    b = v[0];
    r.cls = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if ($signed(v[i]) > b) begin
        b = v[i];
        r.cls = i[1:0];
      end
    end
    r.score = b;
    r.last = last;
    return r;
  endfunction

  function automatic logic [3:0][31:0] mk(
    input int a, input int b, input int c, input int d);
    logic [3:0][31:0] v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  // called at a negedge; returns at the negedge after capture
  task automatic send(input logic [3:0][31:0] v,
                      input logic last, input bit push);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_wait: in_ready=%b required 1",
               in_ready);
    end
    in_data = v;
    in_valid = 1'b1;
    if (push) sbq.push_back(model(v, last));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // waits for out_valid; consumes it when out_ready is high
  task automatic get_out(output res_t obs);
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    obs = {out_class, out_score, out_last};
    if (!out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_wait: out_valid=%b required 1",
               out_valid);
    end
    if (out_ready) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: rdy=%b vld=%b required 1 0",
               in_ready, out_valid);
    end
    n_chk++;
    if ({out_class, out_score, out_last, out_count}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_out: cls=%0d sc=%0d last=%b cnt=%0d required 0",
               out_class, out_score, out_last, out_count);
    end
    res_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    res_t obs, e;
    int lat = 0;
    in_data = mk(5, -3, 9, 2);
    in_valid = 1'b1;
    sbq.push_back(model(in_data, 1'b0));
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 50);
    n_chk++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d required 4", lat);
    end
    get_out(obs);
    e = sbq.pop_front();
    n_chk++;
    if (obs !== e || e.cls !== 2'd2 || e.score !== 32'd9) begin
      n_fail++;
      $display("FAIL basic_result: got %h required %h", obs, e);
    end
    n_chk++;
    if (out_count !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d required 1",
               out_count);
    end
  endtask

  task automatic test_patterns;
    res_t obs, e;
    logic [3:0][31:0] v[4];
    v[0] = mk(7, 7, 1, 7);
    v[1] = mk(-8, -8, -8, -8);
    v[2] = mk(-100, -2, -50, -2);
    v[3] = mk(32'h8000_0000, 32'h8000_0000,
              32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      send(v[i], 1'b0, 1'b1);
      get_out(obs);
      e = sbq.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL pattern_%0d: got %h required %h",
                 i, obs, e);
      end
    end
  endtask

  task automatic test_backpressure;
    res_t obs, held, e;
    out_ready = 1'b0;
    send(mk(1, 4, 3, 2), 1'b0, 1'b1);
    get_out(held);
    in_data = mk(-1, -2, 6, -3);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {out_class, out_score, out_last};
      n_chk++;
      if (!out_valid || in_ready || obs !== held) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b got %h required %h",
                 i, out_valid, in_ready, obs, held);
      end
    end
    e = sbq.pop_front();
    n_chk++;
    if (held !== e) begin
      n_fail++;
      $display("FAIL bp_first: got %h required %h", held, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    sbq.push_back(model(in_data, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    get_out(obs);
    e = sbq.pop_front();
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL bp_second: got %h required %h", obs, e);
    end
  endtask

  task automatic test_done;
    res_t obs, e;
    logic [3:0][31:0] v[5];
    logic lst[5];
    v[0] = mk(1, 2, 3, 4);  lst[0] = 1'b0;
    v[1] = mk(9, 2, 3, 4);  lst[1] = 1'b1;
    v[2] = mk(1, 8, 3, 4);  lst[2] = 1'b0;
    v[3] = mk(0, 0, 5, 0);  lst[3] = 1'b1;
    v[4] = mk(3, 0, 5, 6);  lst[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        in_done = 1'b1;
        @(negedge clk);
        in_done = 1'b0;
        repeat (2) @(negedge clk);
      end
      send(v[i], lst[i], 1'b1);
      if (i == 1) begin
        in_done = 1'b1;
        @(negedge clk);
        in_done = 1'b0;
      end
      get_out(obs);
      e = sbq.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL done_%0d: got %h required %h",
                 i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    res_t obs, e;
    send(mk(4, 3, 2, 1), 1'b0, 1'b0);
    res_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: vld=%b rdy=%b cnt=%0d required 0 1 0",
               out_valid, in_ready, out_count);
    end
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    send(mk(-5, -6, -1, -7), 1'b0, 1'b1);
    get_out(obs);
    e = sbq.pop_front();
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mid_next: got %h required %h", obs, e);
    end
  endtask

  task automatic test_count_wrap;
    res_t obs, e;
    logic [1:0] exp_c;
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send(mk(i, 2 * i, -i, 1), 1'b0, 1'b1);
      get_out(obs);
      e = sbq.pop_front();
      exp_c = 2'(i + 1);
      n_chk++;
      if (w_out_count !== exp_c || obs !== e) begin
        n_fail++;
        $display("FAIL wrap_%0d: cnt=%0d res=%h required %0d %h",
                 i, w_out_count, obs, exp_c, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_done();
    test_reset_mid();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
